// File: rtl/pll_reset_sequencer.sv
// Lock-qualified staged reset sequencer: synchronises the PLL lock flag, waits for a stable
// interval, then releases rst_stage bits one at a time; any lock loss re-asserts all of them.
module pll_reset_sequencer #(
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned STAGE_GAP          = 16,
   parameter int unsigned NUM_STAGES         = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked,
   output logic [NUM_STAGES-1:0] rst_stage,
   output logic                  ready,
   output logic [7:0]            lock_loss_count
);

   localparam int unsigned StabW = $clog2(LOCK_STABLE_CYCLES);
   localparam int unsigned GapW  = $clog2(STAGE_GAP) + 1;
   localparam int unsigned IdxW  = $clog2(NUM_STAGES) + 1;

   localparam logic [StabW-1:0] StabLast = StabW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [GapW-1:0]  GapLast  = GapW'(STAGE_GAP - 1);
   localparam logic [IdxW-1:0]  IdxLast  = IdxW'(NUM_STAGES - 1);

   typedef enum logic [1:0] {
      StWaitLock,
      StStabilize,
      StRelease,
      StRun
   } state_e;

   state_e                state_q, state_d;
   logic                  sync1_q, sync1_d;
   logic                  locked_s_q, locked_s_d;
   logic [StabW-1:0]      stab_cnt_q, stab_cnt_d;
   logic [GapW-1:0]       gap_cnt_q, gap_cnt_d;
   logic [IdxW-1:0]       stage_idx_q, stage_idx_d;
   logic [NUM_STAGES-1:0] rst_stage_q, rst_stage_d;
   logic                  ready_q, ready_d;
   logic [7:0]            loss_cnt_q, loss_cnt_d;
   logic                  lock_lost;

   always_comb begin
      sync1_d     = pll_locked;
      locked_s_d  = sync1_q;
      state_d     = state_q;
      stab_cnt_d  = stab_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      stage_idx_d = stage_idx_q;
      rst_stage_d = rst_stage_q;
      ready_d     = ready_q;
      loss_cnt_d  = loss_cnt_q;
      lock_lost   = !locked_s_q && (state_q != StWaitLock);

      case (state_q)
         StWaitLock: begin
            rst_stage_d = '1;
            ready_d     = 1'b0;
            stab_cnt_d  = '0;
            gap_cnt_d   = '0;
            stage_idx_d = '0;
            if (locked_s_q) begin
               state_d = StStabilize;
            end
         end
         StStabilize: begin
            if (stab_cnt_q == StabLast) begin
               state_d        = StRelease;
               rst_stage_d[0] = 1'b0;
               gap_cnt_d      = '0;
               stage_idx_d    = '0;
            end else begin
               stab_cnt_d = stab_cnt_q + 1'b1;
            end
         end
         StRelease: begin
            if (stage_idx_q == IdxLast) begin
               state_d = StRun;
               ready_d = 1'b1;
            end else if (gap_cnt_q == GapLast) begin
               gap_cnt_d   = '0;
               stage_idx_d = stage_idx_q + 1'b1;
               for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                  if (i == 32'(stage_idx_d)) begin
                     rst_stage_d[i] = 1'b0;
                  end
               end
            end else begin
               gap_cnt_d = gap_cnt_q + 1'b1;
            end
         end
         StRun: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d = StWaitLock;
         end
      endcase

      // Lock loss outranks whatever the state decode chose above.
      if (lock_lost) begin
         state_d     = StWaitLock;
         rst_stage_d = '1;
         ready_d     = 1'b0;
         stab_cnt_d  = '0;
         gap_cnt_d   = '0;
         stage_idx_d = '0;
         if (state_q == StRun && loss_cnt_q != 8'hFF) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         locked_s_q  <= 1'b0;
         state_q     <= StWaitLock;
         stab_cnt_q  <= '0;
         gap_cnt_q   <= '0;
         stage_idx_q <= '0;
         rst_stage_q <= '1;
         ready_q     <= 1'b0;
         loss_cnt_q  <= 8'd0;
      end else begin
         sync1_q     <= sync1_d;
         locked_s_q  <= locked_s_d;
         state_q     <= state_d;
         stab_cnt_q  <= stab_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         stage_idx_q <= stage_idx_d;
         rst_stage_q <= rst_stage_d;
         ready_q     <= ready_d;
         loss_cnt_q  <= loss_cnt_d;
      end
   end

   assign rst_stage       = rst_stage_q;
   assign ready           = ready_q;
   assign lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: a default instance (A) and a minimal instance (B), checked
// every cycle against a lock-run model through a scoreboard, plus fixed-value table checks.
module tb_pll_reset_sequencer;

   logic       clk = 1'b0;
   logic       rst_a, lock_a, rst_b, lock_b;
   logic [2:0] stage_a;
   logic       ready_a;
   logic [7:0] cnt_a;
   logic [0:0] stage_b;
   logic       ready_b;
   logic [7:0] cnt_b;

   always #5 clk = ~clk;

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(1024),
      .STAGE_GAP         (16),
      .NUM_STAGES        (3)
   ) u_dut_a (
      .clk            (clk),
      .rst            (rst_a),
      .pll_locked     (lock_a),
      .rst_stage      (stage_a),
      .ready          (ready_a),
      .lock_loss_count(cnt_a)
   );

   pll_reset_sequencer #(
      .LOCK_STABLE_CYCLES(2),
      .STAGE_GAP         (1),
      .NUM_STAGES        (1)
   ) u_dut_b (
      .clk            (clk),
      .rst            (rst_b),
      .pll_locked     (lock_b),
      .rst_stage      (stage_b),
      .ready          (ready_b),
      .lock_loss_count(cnt_b)
   );

   // run = consecutive edges on which the synchronised lock was high since the last drop/reset.
   typedef struct packed {
      logic s1;
      logic s2;
      int   run;
      int   cnt;
   } mdl_t;

   typedef struct packed {
      logic [2:0] st_a;
      logic       rd_a;
      logic [7:0] cnt_a;
      logic       st_b;
      logic       rd_b;
      logic [7:0] cnt_b;
   } exp_t;

   typedef struct {
      int         n;
      logic       r;
      logic       l;
      logic [2:0] st;
      logic       rd;
      logic [7:0] cn;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   cycle  = 0;
   mdl_t ma = '0;
   mdl_t mb = '0;
   exp_t sb_q[$];
   vec_t vecs[17];

   function automatic mdl_t mdl_next(mdl_t m, logic r, logic lk, int l, int g, int n);
      mdl_t nx = m;
      if (r) begin
         nx = '0;
      end else begin
         nx.s1 = lk;
         nx.s2 = m.s1;
         if (m.s2) begin
            if (m.run < 100000) nx.run = m.run + 1;
         end else begin
            if (m.run >= l + (n - 1) * g + 2 && m.cnt < 255) nx.cnt = m.cnt + 1;
            nx.run = 0;
         end
      end
      return nx;
   endfunction

   function automatic logic [7:0] mdl_stage(mdl_t m, int l, int g, int n);
      logic [7:0] s = '0;
      for (int k = 0; k < n; k++) s[k] = (m.run < l + k * g + 1);
      return s;
   endfunction

   function automatic logic mdl_ready(mdl_t m, int l, int g, int n);
      return m.run >= l + (n - 1) * g + 2;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %0h expected %0h", name, cycle, got, exp);
      end
   endtask

   task automatic step(input logic ra, input logic la, input logic rb, input logic lb);
      exp_t       e;
      exp_t       got;
      logic [7:0] tmp;
      rst_a  = ra;
      lock_a = la;
      rst_b  = rb;
      lock_b = lb;
      ma = mdl_next(ma, ra, la, 1024, 16, 3);
      mb = mdl_next(mb, rb, lb, 2, 1, 1);
      tmp     = mdl_stage(ma, 1024, 16, 3);
      e.st_a  = tmp[2:0];
      e.rd_a  = mdl_ready(ma, 1024, 16, 3);
      e.cnt_a = 8'(ma.cnt);
      tmp     = mdl_stage(mb, 2, 1, 1);
      e.st_b  = tmp[0];
      e.rd_b  = mdl_ready(mb, 2, 1, 1);
      e.cnt_b = 8'(mb.cnt);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      cycle++;
      got = sb_q.pop_front();
      check("sb_a", {20'd0, stage_a, ready_a, cnt_a}, {20'd0, got.st_a, got.rd_a, got.cnt_a});
      check("sb_b", {22'd0, stage_b, ready_b, cnt_b}, {22'd0, got.st_b, got.rd_b, got.cnt_b});
   endtask

   task automatic run_a(input int n, input logic r, input logic l);
      for (int i = 0; i < n; i++) step(r, l, 1'b1, 1'b0);
   endtask

   task automatic run_b(input int n, input logic r, input logic l);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, r, l);
   endtask

   task automatic check_a(input string name, input logic [2:0] st, input logic rd,
                          input logic [7:0] cn);
      check({name, "_stage"}, 32'(stage_a), 32'(st));
      check({name, "_ready"}, 32'(ready_a), 32'(rd));
      check({name, "_count"}, 32'(cnt_a), 32'(cn));
   endtask

   task automatic check_b(input string name, input logic st, input logic rd,
                          input logic [7:0] cn);
      check({name, "_stage"}, 32'(stage_b), 32'(st));
      check({name, "_ready"}, 32'(ready_b), 32'(rd));
      check({name, "_count"}, 32'(cnt_b), 32'(cn));
   endtask

   initial begin
      rst_a  = 1'b1;
      lock_a = 1'b0;
      rst_b  = 1'b1;
      lock_b = 1'b0;

      // Clean lock, loss in RUN, relock; E0 is the first edge with lock high.
      vecs[0]  = '{4,    1'b1, 1'b0, 3'b111, 1'b0, 8'd0};
      vecs[1]  = '{1026, 1'b0, 1'b1, 3'b111, 1'b0, 8'd0};
      vecs[2]  = '{1,    1'b0, 1'b1, 3'b110, 1'b0, 8'd0};
      vecs[3]  = '{15,   1'b0, 1'b1, 3'b110, 1'b0, 8'd0};
      vecs[4]  = '{1,    1'b0, 1'b1, 3'b100, 1'b0, 8'd0};
      vecs[5]  = '{15,   1'b0, 1'b1, 3'b100, 1'b0, 8'd0};
      vecs[6]  = '{1,    1'b0, 1'b1, 3'b000, 1'b0, 8'd0};
      vecs[7]  = '{1,    1'b0, 1'b1, 3'b000, 1'b1, 8'd0};
      vecs[8]  = '{5,    1'b0, 1'b1, 3'b000, 1'b1, 8'd0};
      vecs[9]  = '{1,    1'b0, 1'b0, 3'b000, 1'b1, 8'd0};
      vecs[10] = '{1,    1'b0, 1'b0, 3'b000, 1'b1, 8'd0};
      vecs[11] = '{1,    1'b0, 1'b0, 3'b111, 1'b0, 8'd1};
      vecs[12] = '{10,   1'b0, 1'b0, 3'b111, 1'b0, 8'd1};
      vecs[13] = '{1026, 1'b0, 1'b1, 3'b111, 1'b0, 8'd1};
      vecs[14] = '{1,    1'b0, 1'b1, 3'b110, 1'b0, 8'd1};
      vecs[15] = '{32,   1'b0, 1'b1, 3'b000, 1'b0, 8'd1};
      vecs[16] = '{1,    1'b0, 1'b1, 3'b000, 1'b1, 8'd1};

      for (int i = 0; i < 17; i++) begin
         run_a(vecs[i].n, vecs[i].r, vecs[i].l);
         check_a($sformatf("vec%0d", i), vecs[i].st, vecs[i].rd, vecs[i].cn);
      end

      // Glitch during STABILIZE restarts the interval.
      run_a(4, 1'b1, 1'b0);
      run_a(502, 1'b0, 1'b1);
      run_a(3, 1'b0, 1'b0);
      run_a(1026, 1'b0, 1'b1);
      check_a("glitch_hold", 3'b111, 1'b0, 8'd0);
      run_a(1, 1'b0, 1'b1);
      check_a("glitch_rel0", 3'b110, 1'b0, 8'd0);

      // Loss between stage 0 and stage 1 release.
      run_a(4, 1'b1, 1'b0);
      run_a(1030, 1'b0, 1'b1);
      run_a(2, 1'b0, 1'b0);
      check_a("relloss_pre", 3'b110, 1'b0, 8'd0);
      run_a(1, 1'b0, 1'b0);
      check_a("relloss_post", 3'b111, 1'b0, 8'd0);

      // Reset mid-RELEASE with lock held high.
      run_a(4, 1'b1, 1'b0);
      run_a(1047, 1'b0, 1'b1);
      check_a("midrst_pre", 3'b100, 1'b0, 8'd0);
      run_a(1, 1'b1, 1'b1);
      check_a("midrst_post", 3'b111, 1'b0, 8'd0);
      run_a(1026, 1'b0, 1'b1);
      check_a("midrst_hold", 3'b111, 1'b0, 8'd0);
      run_a(1, 1'b0, 1'b1);
      check_a("midrst_rel0", 3'b110, 1'b0, 8'd0);

      // Minimal parameters: stage 0 at E0+4, ready at E0+5.
      run_b(4, 1'b1, 1'b0);
      check_b("min_reset", 1'b1, 1'b0, 8'd0);
      run_b(4, 1'b0, 1'b1);
      check_b("min_hold", 1'b1, 1'b0, 8'd0);
      run_b(1, 1'b0, 1'b1);
      check_b("min_rel0", 1'b0, 1'b0, 8'd0);
      run_b(1, 1'b0, 1'b1);
      check_b("min_ready", 1'b0, 1'b1, 8'd0);

      // 300 losses from RUN saturate the counter.
      for (int i = 0; i < 300; i++) begin
         run_b(3, 1'b0, 1'b0);
         run_b(6, 1'b0, 1'b1);
         if (i == 0 || i == 253 || i == 254 || i == 299) begin
            check_b($sformatf("sat%0d", i), 1'b0, 1'b1, (i < 255) ? 8'(i + 1) : 8'd255);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Lock-qualified reset sequencer in the 20 MHz PLL output clock domain. It synchronises the PLL's asynchronous `locked` flag and waits for a programmable stable-lock interval. It then releases a set of staged active-high resets to the downstream rflink logic, one stage at a time, and re-asserts all of them immediately if lock is lost. It also counts lock-loss events for status readout.

## Interface
Parameters:
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronised-locked cycles required before release. Legal range ≥ 2.
- `STAGE_GAP`, default 16: cycles between successive stage releases. Legal range ≥ 1.
- `NUM_STAGES`, default 3: number of staged reset outputs. Legal range 1..8.

Ports:
- `clk`  input  1  PLL output clock (20 MHz outclk_0).
- `rst`  input  1  synchronous, active-high reset.
- `pll_locked`  input  1  raw PLL lock flag, asynchronous to `clk`.
- `rst_stage`  output  NUM_STAGES  per-stage active-high reset. Bit 0 releases first.
- `ready`  output  1  high when all stages are released and the block is in RUN.
- `lock_loss_count`  output  8  saturating count of lock losses seen while in RUN.

## Operation
- Synchroniser: `pll_locked` passes through 2 flops to produce `locked_s`. Both flops reset to 0. The FSM uses only `locked_s`.
- Counters:
  - Stability counter: width $clog2(LOCK_STABLE_CYCLES).
  - Gap counter: width $clog2(STAGE_GAP)+1.
  - Stage index: width $clog2(NUM_STAGES)+1.
  - All counters reset to 0.
- FSM states are WAIT_LOCK, STABILIZE, RELEASE, RUN. Reset state is WAIT_LOCK.
- WAIT_LOCK:
  - Drives `rst_stage` all ones and `ready` = 0.
  - On `locked_s`=1, moves to STABILIZE with the stability counter = 0.
- STABILIZE:
  - Increments the stability counter each cycle.
  - On `locked_s`=0, returns to WAIT_LOCK. No count increment.
  - When the counter equals LOCK_STABLE_CYCLES-1 and `locked_s`=1, moves to RELEASE. On the same edge it clears `rst_stage[0]` and sets the gap counter and stage index to 0.
- RELEASE:
  - The gap counter increments each cycle.
  - When the gap counter reaches STAGE_GAP-1, the next stage bit clears, the stage index increments and the gap counter returns to 0.
  - After the last stage clears, the next edge moves to RUN and sets `ready`=1.
  - With NUM_STAGES=1, RUN is entered on the edge after stage 0 clears.
- RUN: holds all stages released and `ready`=1.
- Lock loss:
  - `locked_s`=0 in STABILIZE, RELEASE or RUN causes the next edge to set all `rst_stage` bits to 1, `ready` to 0, the state to WAIT_LOCK and all counters to 0.
  - `lock_loss_count` increments only when the loss is taken from RUN, and saturates at 255.
- `rst`=1 overrides everything on the next edge:
  - Synchroniser flops → 0.
  - State → WAIT_LOCK.
  - `rst_stage` → all ones.
  - `ready` → 0.
  - `lock_loss_count` → 0.
  - All counters → 0.
  - Mid-sequence reset abandons the release in progress. There is no partial release.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Timing
- Reset values: `rst_stage` = all ones, `ready` = 0, `lock_loss_count` = 0.
- Edge references:
  - E0 is the first edge sampling `pll_locked`=1.
  - `locked_s` is high after E1.
  - The FSM sees `locked_s` at T0 = E2 and enters STABILIZE.
- Release schedule (L = LOCK_STABLE_CYCLES, G = STAGE_GAP, N = NUM_STAGES):
  - `rst_stage[0]` is low after edge T0+L.
  - `rst_stage[k]` is low after edge T0+L+k·G.
  - `ready` is high after edge T0+L+(N-1)·G+1.
- With defaults: stage 0/1/2 release at T0+1024/1040/1056, and `ready` asserts at T0+1057.
- Lock-loss response: `pll_locked` falls before edge F. `locked_s` is low after F+1. `rst_stage` is all ones and `ready`=0 after F+2.
- `rst_stage` bits never re-assert individually. Bits are monotonically released within one sequence and re-asserted together.

## Test plan
- Clean lock, defaults: `rst` high 4 cycles, then `pll_locked`=1 before E0 → `rst_stage` clears 3'b110/3'b100/3'b000 at E0+1026/1042/1058, and `ready`=1 at E0+1059.
- Glitch in STABILIZE: `pll_locked` low for 3 cycles at T0+500, then high → the sequence restarts. Stage 0 releases 1024 edges after the new T0. `lock_loss_count` stays 0.
- Lock loss in RUN: drop `pll_locked` after `ready` → all stages high and `ready`=0 two edges later, `lock_loss_count`=1. Relock → full sequence repeats.
- Loss during RELEASE (after stage 0, before stage 1) → all stages re-asserted, count unchanged. Repeat 300 losses from RUN → `lock_loss_count` saturates at 255.
- `rst` asserted at T0+1045 (mid-RELEASE) with `pll_locked` still high → all stages high and `ready`=0 next edge. After deassert, the sequence restarts via the 2-cycle synchroniser.
- Parameter sweep: NUM_STAGES=1, STAGE_GAP=1, LOCK_STABLE_CYCLES=2 → stage 0 releases at T0+2, `ready` at T0+3.
